// File: rtl/gpu_mem_pkg.sv
// Shared types and defaults for the GPU memory responder and its LSU clients.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpu_mem_pkg;

  // Responder FSM: wait for a request, count out the access latency, hold the response.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mem_state_e;

  localparam int DEF_NUM_CHANNELS = 4;
  localparam int DEF_ADDR_BITS    = 8;
  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_LATENCY      = 2;

  // Access counter width: wide enough for LATENCY up to 15.
  localparam int CNT_BITS = 4;

  // Width of a channel index; a single channel still gets a 1-bit index.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester after last_grant, wrapping around.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is used.
// Ports: req (request vector), last_grant (index of previous winner),
//        grant (one-hot winner, all zero if no request), grant_idx (winner index).
module rr_arbiter
  import gpu_mem_pkg::*;
#(
  parameter  int NUM_CHANNELS = DEF_NUM_CHANNELS,
  localparam int IDX_W        = idx_bits(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic [IDX_W-1:0]        last_grant,
  output logic [NUM_CHANNELS-1:0] grant,
  output logic [IDX_W-1:0]        grant_idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk last_grant+1 .. last_grant+NUM_CHANNELS so last_grant itself is checked last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_CHANNELS);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Multi-channel memory responder: serves one LSU read/write at a time from an internal RAM.
// Latency: response rises LATENCY edges after acceptance (accepting edge counts as the first).
// Backpressure: response held until resp_ready on the serving channel; req_ready low while busy.
// Ports: clk, reset (async, active high); per-channel req_valid/req_write/req_addr/req_wdata
//        with req_ready grant; per-channel resp_valid/resp_rdata with resp_ready.
module mem_responder
  import gpu_mem_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int ADDR_BITS    = DEF_ADDR_BITS,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int LATENCY      = DEF_LATENCY
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CHANNELS-1:0]              req_valid,
  input  logic [NUM_CHANNELS-1:0]              req_write,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] req_addr,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] req_wdata,
  output logic [NUM_CHANNELS-1:0]              req_ready,
  output logic [NUM_CHANNELS-1:0]              resp_valid,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] resp_rdata,
  input  logic [NUM_CHANNELS-1:0]              resp_ready
);

  localparam int IDX_W = idx_bits(NUM_CHANNELS);
  localparam int DEPTH = 2 ** ADDR_BITS;
  // Final ACCESS count value; ACCESS lasts LATENCY-1 cycles.
  localparam logic [CNT_BITS-1:0] ACC_LAST = CNT_BITS'((LATENCY > 1) ? LATENCY - 2 : 0);

  logic [DATA_BITS-1:0] mem [DEPTH];

  mem_state_e           state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [IDX_W-1:0]     ch_q, ch_d;
  logic                 write_q, write_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 gap_q, gap_d;

  logic [NUM_CHANNELS-1:0] arb_grant;
  logic [IDX_W-1:0]        arb_idx;
  logic                    accept;
  logic                    win_write;
  logic [ADDR_BITS-1:0]    win_addr;
  logic [DATA_BITS-1:0]    win_wdata;

  rr_arbiter #(
    .NUM_CHANNELS(NUM_CHANNELS)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  // Grant is offered only in a free IDLE cycle; reset forces it low even though state is IDLE.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !gap_q && !reset) begin
      req_ready = arb_grant;
    end
    accept    = |req_ready;
    win_write = req_write[arb_idx];
    win_addr  = req_addr[arb_idx];
    win_wdata = req_wdata[arb_idx];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    ch_d         = ch_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    gap_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ch_d         = arb_idx;
          write_d      = win_write;
          addr_d       = win_addr;
          wdata_d      = win_wdata;
          last_grant_d = arb_idx;
          cnt_d        = '0;
          if (LATENCY > 1) begin
            state_d = ACCESS;
          end else begin
            // Single-cycle build: the latched fields are not yet valid, use the winner directly.
            state_d = RESP;
            rdata_d = win_write ? win_wdata : mem[win_addr];
          end
        end
      end
      ACCESS: begin
        if (cnt_q == ACC_LAST) begin
          state_d = RESP;
          rdata_d = write_q ? wdata_q : mem[addr_q];
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      RESP: begin
        if (resp_ready[ch_q]) begin
          state_d = IDLE;
          // One dead IDLE cycle after each response: back-to-back spacing is LATENCY+2.
          gap_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= IDX_W'(NUM_CHANNELS - 1);
      ch_q         <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      gap_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      ch_q         <= ch_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      gap_q        <= gap_d;
    end
  end

  // Memory contents survive reset; writes commit on the accepting edge.
  always_ff @(posedge clk) begin
    if (accept && win_write) begin
      mem[win_addr] <= win_wdata;
    end
  end

  always_comb begin
    resp_valid = '0;
    resp_rdata = '0;
    if (state_q == RESP) begin
      resp_valid[ch_q] = 1'b1;
      resp_rdata[ch_q] = rdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [N-1:0]         req_valid, req_write, req_ready, resp_valid, resp_ready;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata, resp_rdata;

  logic [N-1:0]         req_valid1, req_write1, req_ready1, resp_valid1, resp_ready1;
  logic [N-1:0][AW-1:0] req_addr1;
  logic [N-1:0][DW-1:0] req_wdata1, resp_rdata1;

  mem_responder #(.NUM_CHANNELS(N), .ADDR_BITS(AW), .DATA_BITS(DW), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_ready(resp_ready)
  );

  mem_responder #(.NUM_CHANNELS(N), .ADDR_BITS(AW), .DATA_BITS(DW), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_write(req_write1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .req_ready(req_ready1), .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_ready(resp_ready1)
  );

  int tests = 0;
  int fails = 0;

  // Reference memory per instance: what each address must hold by the rules of the block.
  logic [DW-1:0] model_mem [2][256];
  logic [AW-1:0] known [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] rdy_vec(input bit which);
    return which ? req_ready1 : req_ready;
  endfunction
  function automatic logic [N-1:0] rv_vec(input bit which);
    return which ? resp_valid1 : resp_valid;
  endfunction
  function automatic logic [N*DW-1:0] rd_vec(input bit which);
    return which ? resp_rdata1 : resp_rdata;
  endfunction

  task automatic set_valid(input bit which, input logic [N-1:0] v);
    if (which) req_valid1 = v; else req_valid = v;
  endtask
  task automatic set_rresp(input bit which, input logic [N-1:0] v);
    if (which) resp_ready1 = v; else resp_ready = v;
  endtask
  task automatic set_req(input bit which, input logic [1:0] ch, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (which) begin
      req_write1[ch] = wr; req_addr1[ch] = a; req_wdata1[ch] = d;
    end else begin
      req_write[ch] = wr; req_addr[ch] = a; req_wdata[ch] = d;
    end
  endtask

  // Round-robin rule: first valid channel searching from last+1, wrapping.
  function automatic int rr_next(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (((v >> ((last + k) % N)) & N'(1)) != '0) return (last + k) % N;
    end
    return -1;
  endfunction

  // One complete transaction on a channel, with optional response stall and an intruding ch3 request.
  task automatic issue(input bit which, input logic [1:0] ch, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int stall, input int exp_wait, input int exp_lat,
                       input bit intrude, input string tag);
    logic [DW-1:0]   exp_d;
    logic [N*DW-1:0] exp_vec;
    logic [N-1:0]    onehot;
    int n;
    onehot  = N'(1) << ch;
    exp_d   = wr ? d : model_mem[which][a];
    exp_vec = '0;
    exp_vec[ch*DW +: DW] = exp_d;
    set_req(which, ch, wr, a, d);
    set_valid(which, onehot);
    set_rresp(which, (stall > 0) ? ~onehot : '1);
    #1;
    n = 0;
    while (rdy_vec(which) != onehot && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, ":grant"}, 32'(rdy_vec(which)), 32'(onehot));
    if (exp_wait >= 0) check({tag, ":wait"}, 32'(n), 32'(exp_wait));
    @(posedge clk);
    if (wr) model_mem[which][a] = d;
    #1;
    set_valid(which, '0);
    if (intrude) begin
      set_req(which, 2'd3, 1'b1, 8'h55, 8'h99);
      set_valid(which, 4'b1000);
    end
    #1;
    n = 1;
    while (rv_vec(which) == '0 && n < 20) begin
      check({tag, ":busy_rdy"}, 32'(rdy_vec(which)), 32'(0));
      @(posedge clk); #2; n++;
    end
    check({tag, ":resp_rdy"}, 32'(rdy_vec(which)), 32'(0));
    set_valid(which, '0);
    check({tag, ":lat"}, 32'(n), 32'(exp_lat));
    check({tag, ":rvalid"}, 32'(rv_vec(which)), 32'(onehot));
    check({tag, ":rdata"}, 32'(rd_vec(which)), 32'(exp_vec));
    for (int s = 0; s < stall; s++) begin
      set_valid(which, ~onehot);
      #1;
      check({tag, ":stall_rdy"}, 32'(rdy_vec(which)), 32'(0));
      check({tag, ":stall_rvalid"}, 32'(rv_vec(which)), 32'(onehot));
      check({tag, ":stall_rdata"}, 32'(rd_vec(which)), 32'(exp_vec));
      @(posedge clk); #1;
    end
    set_valid(which, '0);
    set_rresp(which, '1);
    #1;
    @(posedge clk); #1;
    check({tag, ":done"}, 32'(rv_vec(which)), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int last;
    int exp_g;
    int gidx [$];
    int gcyc [$];
    logic [1:0]    rch;
    logic [AW-1:0] ra;
    logic [DW-1:0] rdat;
    logic [DW-1:0] wd [N];
    bit            rwr;

    // Reset state: grants and responses must be quiet even with every channel requesting.
    reset = 1'b1;
    req_valid = '1; req_write = '0; req_addr = '0; req_wdata = '0; resp_ready = '1;
    req_valid1 = '1; req_write1 = '0; req_addr1 = '0; req_wdata1 = '0; resp_ready1 = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'(0));
    check("rst_rvalid", 32'(resp_valid), 32'(0));
    check("rst_rdata", 32'(resp_rdata), 32'(0));
    check("rst_ready_l1", 32'(req_ready1), 32'(0));
    check("rst_rvalid_l1", 32'(resp_valid1), 32'(0));
    reset = 1'b0;
    req_valid = '0; req_valid1 = '0;
    #1;

    // Basic write then read-back on another channel.
    issue(1'b0, 2'd0, 1'b1, 8'h10, 8'hA5, 0, 0, 2, 1'b0, "w10");
    issue(1'b0, 2'd1, 1'b0, 8'h10, 8'h00, 0, 1, 2, 1'b0, "r10");

    // Single-cycle-latency build.
    issue(1'b1, 2'd0, 1'b1, 8'hFF, 8'hFF, 0, 0, 1, 1'b0, "l1_w");
    issue(1'b1, 2'd0, 1'b0, 8'hFF, 8'h00, 0, 1, 1, 1'b0, "l1_r");

    // Response stalled 5 cycles while other channels request and assert resp_ready.
    issue(1'b0, 2'd3, 1'b1, 8'h20, 8'h3C, 0, -1, 2, 1'b0, "w20");
    issue(1'b0, 2'd2, 1'b0, 8'h20, 8'h00, 5, 1, 2, 1'b0, "r20_stall");

    // A ch3 write appears during another access and is withdrawn before it could be served.
    issue(1'b0, 2'd1, 1'b1, 8'h55, 8'h11, 0, 1, 2, 1'b0, "w55");
    issue(1'b0, 2'd0, 1'b1, 8'h60, 8'h22, 0, 1, 2, 1'b1, "w60_intr");
    issue(1'b0, 2'd3, 1'b0, 8'h55, 8'h00, 0, 1, 2, 1'b0, "r55");

    // Reset during an in-flight read aborts it; memory and priority follow reset rules.
    issue(1'b0, 2'd1, 1'b1, 8'h40, 8'h77, 0, 1, 2, 1'b0, "w40");
    set_req(1'b0, 2'd1, 1'b0, 8'h40, 8'h00);
    set_valid(1'b0, 4'b0010);
    #1;
    n = 0;
    while (req_ready != 4'b0010 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("abort_grant", 32'(req_ready), 32'(4'b0010));
    @(posedge clk); #1;
    set_valid(1'b0, '0);
    reset = 1'b1;
    set_valid(1'b0, '1);
    #1;
    check("abort_ready", 32'(req_ready), 32'(0));
    check("abort_rvalid", 32'(resp_valid), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    check("abort_rvalid_hold", 32'(resp_valid), 32'(0));
    check("abort_rdata_hold", 32'(resp_rdata), 32'(0));
    reset = 1'b0;
    #1;
    check("post_rst_prio", 32'(req_ready), 32'(4'b0001));
    set_valid(1'b0, '0);
    repeat (2) begin
      @(posedge clk); #1;
      check("post_rst_quiet", 32'(resp_valid), 32'(0));
    end
    issue(1'b0, 2'd0, 1'b0, 8'h40, 8'h00, 0, 0, 2, 1'b0, "r40_kept");
    issue(1'b0, 2'd2, 1'b0, 8'h10, 8'h00, 0, 1, 2, 1'b0, "r10_kept");

    // All four channels requesting continuously from reset: fair rotation, fixed spacing.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      wd[i] = 8'($urandom);
      set_req(1'b0, 2'(i), 1'b1, 8'(8'h80 + i), wd[i]);
    end
    resp_ready = '1;
    req_valid  = '1;
    #1;
    for (int k = 0; k <= 16; k++) begin
      if (req_ready != '0) begin
        check("rr_onehot", 32'($countones(req_ready)), 32'(1));
        for (int i = 0; i < N; i++) begin
          if (req_ready == (N'(1) << i)) begin
            gidx.push_back(i);
            gcyc.push_back(k);
            model_mem[0][8'(8'h80 + i)] = wd[i];
          end
        end
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    check("rr_count", 32'(gidx.size()), 32'(5));
    last = N - 1;
    for (int j = 0; j < gidx.size() && j < 5; j++) begin
      exp_g = rr_next(last, 4'hF);
      check("rr_order", 32'(gidx[j]), 32'(exp_g));
      if (j > 0) check("rr_spacing", 32'(gcyc[j] - gcyc[j-1]), 32'(4));
      last = exp_g;
    end
    repeat (4) @(posedge clk);
    #1;

    // Randomized traffic against the reference memory.
    known = '{8'h10, 8'h20, 8'h55, 8'h60, 8'h40, 8'h80, 8'h81, 8'h82, 8'h83};
    for (int t = 0; t < 25; t++) begin
      rch  = 2'($urandom_range(0, 3));
      rwr  = 1'($urandom_range(0, 1));
      rdat = 8'($urandom);
      if (rwr) begin
        ra = ($urandom_range(0, 1) == 0) ? known[$urandom_range(0, known.size() - 1)] : 8'($urandom);
        known.push_back(ra);
      end else begin
        ra = known[$urandom_range(0, known.size() - 1)];
      end
      issue(1'b0, rch, rwr, ra, rdat, $urandom_range(0, 2), (t == 0) ? -1 : 1, 2, 1'b0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
